// File: rtl/iccm_boot_ctrl.sv
// ICCM boot loader: assembles little-endian 32-bit words from a byte stream
// and writes them to consecutive ICCM addresses until an end marker or a full ICCM.
module iccm_boot_ctrl #(
  parameter int          AW       = 13,
  parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          boot_en_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          rx_valid_i,
  output logic [AW-1:0] iccm_ctrl_addr_o,
  output logic [31:0]   iccm_ctrl_wdata_o,
  output logic          iccm_ctrl_we_o,
  output logic          iccm_wsel_o,
  output logic          core_halt_o,
  output logic          done_o,
  output logic          ovf_o,
  output logic [AW:0]   word_cnt_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    byte_cnt;
  logic [23:0]   partial;
  logic [AW-1:0] addr;
  logic [AW:0]   word_cnt;
  logic [31:0]   wdata;
  logic          ovf;
  logic [31:0]   full_word;
  logic          last_addr;

  assign full_word = {rx_byte_i, partial};
  assign last_addr = (addr == {AW{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    iccm_ctrl_we_o = 1'b0;
    iccm_wsel_o = 1'b0;
    core_halt_o = 1'b1;
    done_o      = 1'b0;
    case (state)
      IDLE:    state_next = boot_en_i ? COLLECT : DONE;
      COLLECT: begin
        if (rx_valid_i && (byte_cnt == 2'd3))
          state_next = (full_word == END_WORD) ? DONE : WRITE;
      end
      WRITE: begin
        iccm_ctrl_we_o = 1'b1;
        state_next     = last_addr ? DONE : COLLECT;
      end
      DONE: begin
        iccm_wsel_o = 1'b1;
        core_halt_o = 1'b0;
        done_o      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The byte counter is already zero while in WRITE, so a byte arriving then
  // becomes byte 0 of the next word; after the last address it is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
      addr     <= '0;
      word_cnt <= '0;
      wdata    <= 32'd0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (rx_valid_i) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              if (full_word != END_WORD) wdata <= full_word;
            end else begin
              partial[{byte_cnt, 3'b000} +: 8] <= rx_byte_i;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          if (last_addr) begin
            ovf <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
            if (rx_valid_i) begin
              partial[7:0] <= rx_byte_i;
              byte_cnt     <= 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign iccm_ctrl_addr_o  = addr;
  assign iccm_ctrl_wdata_o = wdata;
  assign word_cnt_o        = word_cnt;
  assign ovf_o             = ovf;

endmodule

// File: tb/tb_iccm_boot_ctrl.sv
// Directed bench for iccm_boot_ctrl: a default-size instance plus an AW=2
// instance sharing one stimulus stream, with a write logger per instance.
module tb_iccm_boot_ctrl;

  localparam logic [31:0] END_WORD = 32'h0000_0FFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       boot_en;
  logic       rx_valid;
  logic [7:0] rx_byte;

  logic [12:0] addr1;
  logic [31:0] wdata1;
  logic        we1, wsel1, halt1, done1, ovf1;
  logic [13:0] wcnt1;

  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic        we2, wsel2, halt2, done2, ovf2;
  logic [2:0]  wcnt2;

  int n_checks = 0;
  int n_fail = 0;
  int consec_err = 0;
  int wsel_err = 0;
  logic prev_we1 = 1'b0;
  logic prev_we2 = 1'b0;

  logic [12:0] wa1[$];
  logic [31:0] wd1[$];
  logic [1:0]  wa2[$];
  logic [31:0] wd2[$];
  logic [31:0] exp_words[$];

  iccm_boot_ctrl #(.AW(13), .END_WORD(END_WORD)) dut1 (
    .clk_i(clk), .rst_i(rst), .boot_en_i(boot_en), .rx_byte_i(rx_byte),
    .rx_valid_i(rx_valid), .iccm_ctrl_addr_o(addr1), .iccm_ctrl_wdata_o(wdata1),
    .iccm_ctrl_we_o(we1), .iccm_wsel_o(wsel1), .core_halt_o(halt1),
    .done_o(done1), .ovf_o(ovf1), .word_cnt_o(wcnt1)
  );

  iccm_boot_ctrl #(.AW(2), .END_WORD(END_WORD)) dut2 (
    .clk_i(clk), .rst_i(rst), .boot_en_i(boot_en), .rx_byte_i(rx_byte),
    .rx_valid_i(rx_valid), .iccm_ctrl_addr_o(addr2), .iccm_ctrl_wdata_o(wdata2),
    .iccm_ctrl_we_o(we2), .iccm_wsel_o(wsel2), .core_halt_o(halt2),
    .done_o(done2), .ovf_o(ovf2), .word_cnt_o(wcnt2)
  );

  // Log every write away from the active edge and flag protocol violations.
  always @(negedge clk) begin
    if (we1) begin
      wa1.push_back(addr1);
      wd1.push_back(wdata1);
      if (prev_we1) consec_err++;
    end
    if (we2) begin
      wa2.push_back(addr2);
      wd2.push_back(wdata2);
      if (prev_we2) consec_err++;
    end
    prev_we1 = we1;
    prev_we2 = we2;
    if ((wsel1 !== done1) || (halt1 !== ~done1)) wsel_err++;
    if ((wsel2 !== done2) || (halt2 !== ~done2)) wsel_err++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      idle(gap);
    end
  endtask

  task automatic apply_reset(input logic boot);
    rst      = 1'b1;
    boot_en  = boot;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wa1.delete(); wd1.delete(); wa2.delete(); wd2.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;

    // Reset state, then boot disabled goes straight to DONE.
    rst = 1'b1; boot_en = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    @(posedge clk);
    #1;
    check_output("rst_done", done1, 0);
    check_output("rst_halt", halt1, 1);
    check_output("rst_wsel", wsel1, 0);
    check_output("rst_we", we1, 0);
    check_output("rst_wcnt", wcnt1, 0);
    check_output("rst_ovf", ovf1, 0);
    check_output("rst_addr", addr1, 0);
    check_output("rst_wdata", wdata1, 0);
    rst = 1'b0;
    idle(1);
    check_output("noboot_done", done1, 1);
    check_output("noboot_wsel", wsel1, 1);
    check_output("noboot_halt", halt1, 0);
    check_output("noboot_wcnt", wcnt1, 0);
    check_output("noboot_writes", wa1.size(), 0);

    // Two words with gaps, then end marker.
    apply_reset(1'b1);
    send_word(32'h1234_5678, 1);
    send_word(32'hDEAD_BEEF, 1);
    send_word(END_WORD, 1);
    check_output("two_nwr", wa1.size(), 2);
    if (wa1.size() == 2) begin
      check_output("two_a0", wa1[0], 0);
      check_output("two_d0", wd1[0], 32'h1234_5678);
      check_output("two_a1", wa1[1], 1);
      check_output("two_d1", wd1[1], 32'hDEAD_BEEF);
    end
    check_output("two_done", done1, 1);
    check_output("two_wcnt", wcnt1, 2);
    check_output("two_ovf", ovf1, 0);
    check_output("two_wsel", wsel1, 1);
    send_word(32'h5555_AAAA, 0);
    idle(2);
    check_output("done_ignores_rx", wcnt1, 2);

    // Back-to-back bytes; byte 0 of the next word lands during WRITE.
    apply_reset(1'b1);
    send_word(32'h1122_3344, 0);
    send_word(32'hA5A5_0001, 0);
    send_word(32'hCAFE_BABE, 0);
    idle(2);
    check_output("b2b_nwr", wa1.size(), 3);
    if (wa1.size() == 3) begin
      check_output("b2b_a0", wa1[0], 0);
      check_output("b2b_d0", wd1[0], 32'h1122_3344);
      check_output("b2b_a1", wa1[1], 1);
      check_output("b2b_d1", wd1[1], 32'hA5A5_0001);
      check_output("b2b_a2", wa1[2], 2);
      check_output("b2b_d2", wd1[2], 32'hCAFE_BABE);
    end
    check_output("b2b_wcnt", wcnt1, 3);

    // Partial word is held without timeout; boot_en change has no effect.
    boot_en = 1'b0;
    send_byte(8'h0D);
    send_byte(8'hF0);
    idle(40);
    check_output("partial_nwr", wa1.size(), 3);
    check_output("partial_halt", halt1, 1);
    send_byte(8'hAD);
    send_byte(8'h0B);
    idle(2);
    check_output("partial_nwr2", wa1.size(), 4);
    if (wa1.size() == 4) begin
      check_output("partial_a", wa1[3], 3);
      check_output("partial_d", wd1[3], 32'h0BAD_F00D);
    end

    // AW=2 instance fills its ICCM and overflows; 5th word ignored.
    apply_reset(1'b1);
    for (int i = 0; i < 5; i++) send_word(32'h0000_0100 + i, 0);
    idle(2);
    check_output("ovf_nwr", wa2.size(), 4);
    for (int i = 0; i < 4 && i < wa2.size(); i++) begin
      check_output($sformatf("ovf_a%0d", i), wa2[i], i);
      check_output($sformatf("ovf_d%0d", i), wd2[i], 32'h0000_0100 + i);
    end
    check_output("ovf_done", done2, 1);
    check_output("ovf_flag", ovf2, 1);
    check_output("ovf_wcnt", wcnt2, 4);
    check_output("ovf_addr_nowrap", addr2, 3);

    // Reset mid-word discards the partial bytes.
    apply_reset(1'b1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    apply_reset(1'b1);
    send_word(32'h0403_0201, 0);
    idle(2);
    send_word(END_WORD, 0);
    check_output("midrst_nwr", wa1.size(), 1);
    if (wa1.size() == 1) begin
      check_output("midrst_a", wa1[0], 0);
      check_output("midrst_d", wd1[0], 32'h0403_0201);
    end
    check_output("midrst_wcnt", wcnt1, 1);
    check_output("midrst_done", done1, 1);

    // Random words with random byte gaps against a queue of expected words.
    apply_reset(1'b1);
    exp_words.delete();
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      if (w == END_WORD) w = w ^ 32'h1;
      exp_words.push_back(w);
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        idle($urandom_range(0, 2));
      end
    end
    idle(2);
    check_output("rand_wsel_before_end", wsel1, 0);
    send_word(END_WORD, 0);
    check_output("rand_nwr", wa1.size(), 20);
    for (int i = 0; i < 20 && i < wa1.size(); i++) begin
      check_output($sformatf("rand_a%0d", i), wa1[i], i);
      check_output($sformatf("rand_d%0d", i), wd1[i], exp_words[i]);
    end
    check_output("rand_wcnt", wcnt1, 20);
    check_output("rand_done", done1, 1);

    check_output("no_consecutive_we", consec_err, 0);
    check_output("wsel_halt_vs_done", wsel_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
